// File: rtl/pipe_pkg.sv
// Shared pipeline types: ALU op encodings, forwarding select and the ID/EX slot record.
package pipe_pkg;

    localparam int PIPE_DATA_WIDTH     = 32;
    localparam int PIPE_OPCODE_LENGTH  = 4;
    localparam int PIPE_REG_ADDR_WIDTH = 5;

    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_SUB = 4'b0011;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_SLL = 4'b0100;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_SRL = 4'b0101;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_SRA = 4'b0111;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_EQ  = 4'b1000;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_XOR = 4'b1010;
    localparam logic [PIPE_OPCODE_LENGTH-1:0] ALU_SLT = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'd0,
        FWD_MEMWB = 2'd1,
        FWD_EXMEM = 2'd2
    } fwd_sel_e;

    typedef struct packed {
        logic                                 valid;
        logic [PIPE_REG_ADDR_WIDTH-1:0]       rs1;
        logic [PIPE_REG_ADDR_WIDTH-1:0]       rs2;
        logic [PIPE_REG_ADDR_WIDTH-1:0]       rd;
        logic [PIPE_DATA_WIDTH-1:0]           rd1;
        logic [PIPE_DATA_WIDTH-1:0]           rd2;
        logic [PIPE_DATA_WIDTH-1:0]           imm;
        logic [PIPE_OPCODE_LENGTH-1:0]        alu_op;
        logic                                 alu_src;
        logic                                 reg_write;
        logic                                 mem_read;
        logic                                 mem_write;
    } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-EX bus: decoded fields in, forwarding sources in, ALU operands and EX control out.
interface id_ex_stage_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs1;
    logic [REG_ADDR_WIDTH-1:0] id_rs2;
    logic [REG_ADDR_WIDTH-1:0] id_rd;
    logic [DATA_WIDTH-1:0]     id_rd1;
    logic [DATA_WIDTH-1:0]     id_rd2;
    logic [DATA_WIDTH-1:0]     id_imm;
    logic [OPCODE_LENGTH-1:0]  id_alu_op;
    logic                      id_alu_src;
    logic                      id_reg_write;
    logic                      id_mem_read;
    logic                      id_mem_write;
    logic                      flush;

    logic                      exmem_reg_write;
    logic [REG_ADDR_WIDTH-1:0] exmem_rd;
    logic [DATA_WIDTH-1:0]     exmem_result;
    logic                      memwb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] memwb_rd;
    logic [DATA_WIDTH-1:0]     memwb_result;

    logic                      stall;
    logic                      ex_valid;
    logic [DATA_WIDTH-1:0]     SrcA;
    logic [DATA_WIDTH-1:0]     SrcB;
    logic [OPCODE_LENGTH-1:0]  Operation;
    logic [REG_ADDR_WIDTH-1:0] ex_rd;
    logic [DATA_WIDTH-1:0]     ex_store_data;
    logic                      ex_reg_write;
    logic                      ex_mem_read;
    logic                      ex_mem_write;

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
               id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_valid, SrcA, SrcB, Operation, ex_rd, ex_store_data,
               ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_rd1, id_rd2, id_imm,
               id_alu_op, id_alu_src, id_reg_write, id_mem_read, id_mem_write, flush,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_valid, SrcA, SrcB, Operation, ex_rd, ex_store_data,
               ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface

// File: rtl/forward_unit.sv
// Operand forwarding select for the instruction sitting in EX; purely combinational.
module forward_unit
    import pipe_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rs2,
    input  logic                      exmem_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      memwb_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    output fwd_sel_e                  fwd_a,
    output fwd_sel_e                  fwd_b
);

    // x0 is hardwired, so it never takes a bypass; the younger EX/MEM result wins.
    function automatic fwd_sel_e pick(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic                      em_we,
        input logic [REG_ADDR_WIDTH-1:0] em_rd,
        input logic                      mw_we,
        input logic [REG_ADDR_WIDTH-1:0] mw_rd
    );
        if (rs == '0)
            return FWD_REG;
        if (em_we && (em_rd == rs))
            return FWD_EXMEM;
        if (mw_we && (mw_rd == rs))
            return FWD_MEMWB;
        return FWD_REG;
    endfunction

    always_comb begin
        fwd_a = pick(ex_rs1, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
        fwd_b = pick(ex_rs2, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Define ID_EX_PERF_EN to add saturating stall/flush event counters.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int OPCODE_LENGTH  = 4,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]  perf_stall_cnt,
    output logic [31:0]  perf_flush_cnt
`endif
);

    id_ex_t                  ex_q;
    id_ex_t                  ex_d;
    fwd_sel_e                sel_a;
    fwd_sel_e                sel_b;
    logic [DATA_WIDTH-1:0]   fwd_rs1;
    logic [DATA_WIDTH-1:0]   fwd_rs2;
    logic                    load_use;

    // Keyed on registered state, so an asynchronous reset drops the stall at once.
    assign load_use = bus.id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                      ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

    always_comb begin
        ex_d = '0;
        if (!bus.flush && !load_use) begin
            ex_d.valid     = bus.id_valid;
            ex_d.rs1       = bus.id_rs1;
            ex_d.rs2       = bus.id_rs2;
            ex_d.rd        = bus.id_rd;
            ex_d.rd1       = bus.id_rd1;
            ex_d.rd2       = bus.id_rd2;
            ex_d.imm       = bus.id_imm;
            ex_d.alu_op    = bus.id_alu_op;
            ex_d.alu_src   = bus.id_alu_src;
            ex_d.reg_write = bus.id_reg_write;
            ex_d.mem_read  = bus.id_mem_read;
            ex_d.mem_write = bus.id_mem_write;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    forward_unit #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_forward_unit (
        .ex_rs1          (ex_q.rs1),
        .ex_rs2          (ex_q.rs2),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .fwd_a           (sel_a),
        .fwd_b           (sel_b)
    );

    always_comb begin
        case (sel_a)
            FWD_EXMEM: fwd_rs1 = bus.exmem_result;
            FWD_MEMWB: fwd_rs1 = bus.memwb_result;
            default:   fwd_rs1 = ex_q.rd1;
        endcase
        case (sel_b)
            FWD_EXMEM: fwd_rs2 = bus.exmem_result;
            FWD_MEMWB: fwd_rs2 = bus.memwb_result;
            default:   fwd_rs2 = ex_q.rd2;
        endcase
    end

    assign bus.stall         = load_use;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.SrcA          = fwd_rs1;
    assign bus.SrcB          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
    assign bus.ex_store_data = fwd_rs2;
    assign bus.Operation     = ex_q.alu_op;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_write  = ex_q.valid & ex_q.reg_write;
    assign bus.ex_mem_read   = ex_q.valid & ex_q.mem_read;
    assign bus.ex_mem_write  = ex_q.valid & ex_q.mem_write;

`ifdef ID_EX_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (load_use && !bus.flush && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (bus.flush && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed decode/forwarding vectors, monitor compares at negedge.
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW = 32;
    localparam int OL = 4;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    id_ex_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_WIDTH(RW)) bus ();

`ifdef ID_EX_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    id_ex_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .REG_ADDR_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ID_EX_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        int           cyc;
        logic [109:0] vec;
        logic [63:0]  perf;
    } exp_t;

    exp_t  sb[$];
    string names[$];

    task automatic idle_inputs();
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_imm = 0; bus.id_alu_op = 0;
        bus.id_alu_src = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
        bus.flush = 0;
        bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
        bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    endtask

    task automatic dec(input logic v, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2,
                       input logic [RW-1:0] rd, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                       input logic [DW-1:0] imm, input logic [OL-1:0] op, input logic src,
                       input logic rw, input logic mr, input logic mw);
        bus.id_valid = v; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm; bus.id_alu_op = op;
        bus.id_alu_src = src; bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    endtask

    task automatic fwd(input logic ew, input logic [RW-1:0] erd, input logic [DW-1:0] eres,
                       input logic mwe, input logic [RW-1:0] mrd, input logic [DW-1:0] mres);
        bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = mwe; bus.memwb_rd = mrd; bus.memwb_result = mres;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string name, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] st, input logic [OL-1:0] op,
                           input logic [RW-1:0] rd, input logic rw, input logic mr, input logic mw,
                           input logic stl, input logic [31:0] ps, input logic [31:0] pf);
        exp_t e;
        e.cyc  = cyc;
        e.vec  = {v, a, b, st, op, rd, rw, mr, mw, stl};
        e.perf = {ps, pf};
        sb.push_back(e);
        names.push_back(name);
    endtask

    // Monitor: pops every entry due by this cycle and compares against live outputs.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            exp_t         e;
            string        nm;
            logic [109:0] act;
            e  = sb.pop_front();
            nm = names.pop_front();
            act = {bus.ex_valid, bus.SrcA, bus.SrcB, bus.ex_store_data, bus.Operation, bus.ex_rd,
                   bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.stall};
            checks++;
            if (e.cyc != cyc || act !== e.vec) begin
                failures++;
                $display("FAIL %s cyc=%0d/%0d got=%h want=%h", nm, cyc, e.cyc, act, e.vec);
            end
`ifdef ID_EX_PERF_EN
            checks++;
            if ({perf_stall_cnt, perf_flush_cnt} !== e.perf) begin
                failures++;
                $display("FAIL %s_perf got=%h want=%h", nm, {perf_stall_cnt, perf_flush_cnt}, e.perf);
            end
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        step();
        dec(1, 5, 5, 1, 32'h77, 32'h88, 32'h9, ALU_ADD, 0, 1, 1, 0);
        exp_out("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;
        idle_inputs();

        step();
        dec(1, 3, 4, 6, 32'h5, 32'h7, 32'h100, ALU_ADD, 0, 1, 0, 0);
        step();
        fwd(1, 3, 32'h10, 0, 0, 0);
        exp_out("exm_fwd", 1, 32'h10, 32'h7, 32'h7, ALU_ADD, 6, 1, 0, 0, 0, 0, 0);
        step();
        fwd(1, 3, 32'h10, 1, 3, 32'h20);
        exp_out("exm_prio", 1, 32'h10, 32'h7, 32'h7, ALU_ADD, 6, 1, 0, 0, 0, 0, 0);
        step();
        dec(1, 0, 4, 6, 32'h55, 32'h66, 32'h100, ALU_SUB, 1, 1, 0, 0);
        fwd(0, 3, 32'h10, 1, 3, 32'h20);
        exp_out("mwb_fwd", 1, 32'h20, 32'h7, 32'h7, ALU_ADD, 6, 1, 0, 0, 0, 0, 0);
        step();
        dec(1, 2, 0, 5, 32'h1000, 32'h0, 32'h8, ALU_ADD, 1, 1, 1, 0);
        fwd(1, 0, 32'h99, 1, 4, 32'h44);
        exp_out("x0_nofwd", 1, 32'h55, 32'h100, 32'h44, ALU_SUB, 6, 1, 0, 0, 0, 0, 0);
        step();
        dec(1, 1, 5, 7, 32'h11, 32'hBAD, 32'h0, ALU_ADD, 0, 1, 0, 0);
        fwd(0, 0, 0, 0, 0, 0);
        exp_out("lu_stall", 1, 32'h1000, 32'h8, 32'h0, ALU_ADD, 5, 1, 1, 0, 1, 0, 0);
        step();
        fwd(1, 5, 32'hDEAD, 0, 0, 0);
        exp_out("lu_bubble", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        dec(1, 0, 0, 9, 32'h200, 32'h0, 32'h4, ALU_ADD, 1, 1, 1, 0);
        fwd(0, 5, 32'hDEAD, 1, 5, 32'hCAFE);
        exp_out("lu_fwd", 1, 32'h11, 32'hCAFE, 32'hCAFE, ALU_ADD, 7, 1, 0, 0, 0, 1, 0);
        step();
        dec(1, 9, 0, 10, 32'h1, 32'h0, 32'h0, ALU_ADD, 0, 1, 0, 0);
        fwd(0, 0, 0, 0, 0, 0);
        bus.flush = 1;
        exp_out("flush_stl", 1, 32'h200, 32'h4, 32'h0, ALU_ADD, 9, 1, 1, 0, 1, 1, 0);
        step();
        dec(1, 1, 0, 10, 32'h3, 32'h0, 32'h0, ALU_OR, 0, 1, 0, 0);
        bus.flush = 1;
        exp_out("flush_bub", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step();
        dec(1, 1, 2, 0, 32'h30, 32'h40, 32'hC, ALU_ADD, 1, 0, 0, 1);
        bus.flush = 0;
        exp_out("flush2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
        step();
        dec(1, 0, 0, 5, 32'h50, 32'h0, 32'h0, ALU_ADD, 1, 1, 1, 0);
        exp_out("store", 1, 32'h30, 32'hC, 32'h40, ALU_ADD, 0, 0, 0, 1, 0, 1, 2);
        step();
        dec(1, 5, 0, 11, 32'h0, 32'h0, 32'h0, ALU_AND, 0, 1, 0, 0);
        #2;
        reset = 1'b0;
        exp_out("rst_async", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        exp_out("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b1;
        idle_inputs();
        step();
        step();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
